// File: rtl/bram_cfg_dp.sv
// Simple dual-port RAM, one write and one read port, runtime-selectable x32/x16/x8 widths, per-lane write-first bypass.
// Latency: read data 1 cycle after rd_en, or 2 with cfg_out_reg; one result per cycle; hardware clear takes DEPTH cycles.
// Backpressure: none; user reads and writes are dropped while init_busy is high.
module bram_cfg_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            cfg_wr_mode,
    input  logic [1:0]            cfg_rd_mode,
    input  logic                  cfg_out_reg,
    input  logic                  cfg_wr_always,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH+1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH+1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  clear_req,
    output logic                  init_busy
);
    localparam int LANE  = DATA_WIDTH / 4;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   wr_word, rd_word;
    logic [1:0]              wr_sub, rd_sub;
    logic                    idle, rd_go;
    logic [3:0]              u_be, m_be;
    logic [DATA_WIDTH-1:0]   u_dat, m_dat;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [DATA_WIDTH-1:0]   fetch, rd_fmt;

    logic                    s1_vld, out_vld;
    logic [DATA_WIDTH-1:0]   s1_dat, out_dat;

    assign wr_word   = wr_addr[ADDR_WIDTH-1:0];
    assign wr_sub    = wr_addr[ADDR_WIDTH+1:ADDR_WIDTH];
    assign rd_word   = rd_addr[ADDR_WIDTH-1:0];
    assign rd_sub    = rd_addr[ADDR_WIDTH+1:ADDR_WIDTH];
    assign idle      = (state == S_IDLE);
    assign rd_go     = idle && rd_en;
    assign init_busy = (state == S_CLEAR);

    // Narrow writes replicate the payload across lanes so the lane mask alone picks the target.
    always_comb begin
        u_be  = 4'b1111;
        u_dat = wr_data;
        case (cfg_wr_mode)
            2'd1: begin
                u_be  = wr_sub[0] ? 4'b1100 : 4'b0011;
                u_dat = {2{wr_data[2*LANE-1:0]}};
            end
            2'd2: begin
                u_be  = 4'b0001 << wr_sub;
                u_dat = {4{wr_data[LANE-1:0]}};
            end
            default: begin
                u_be  = 4'b1111;
                u_dat = wr_data;
            end
        endcase
        if (!(idle && (wr_en || cfg_wr_always)))
            u_be = 4'b0000;
    end

    always_comb begin
        m_be   = u_be;
        m_addr = wr_word;
        m_dat  = u_dat;
        if (state == S_CLEAR) begin
            m_be   = 4'b1111;
            m_addr = clr_addr;
            m_dat  = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (m_be[i])
                mem[m_addr][i*LANE +: LANE] <= m_dat[i*LANE +: LANE];
    end

    // Write-first: lanes being written to the same word this edge come from the write port.
    always_comb begin
        fetch = mem[rd_word];
        for (int i = 0; i < 4; i++)
            if (u_be[i] && (wr_word == rd_word))
                fetch[i*LANE +: LANE] = u_dat[i*LANE +: LANE];
    end

    always_comb begin
        rd_fmt = '0;
        case (cfg_rd_mode)
            2'd1: rd_fmt[2*LANE-1:0] = rd_sub[0] ? fetch[4*LANE-1:2*LANE] : fetch[2*LANE-1:0];
            2'd2: rd_fmt[LANE-1:0]   = fetch[rd_sub*LANE +: LANE];
            default: rd_fmt = fetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            s1_vld  <= rd_go;
            out_vld <= s1_vld;
            if (rd_go)
                s1_dat <= rd_fmt;
            if (s1_vld)
                out_dat <= s1_dat;
        end
    end

    assign rd_valid = cfg_out_reg ? out_vld : s1_vld;
    assign rd_data  = cfg_out_reg ? out_dat : s1_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            clr_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    if (clr_addr == '1)
                        state <= S_IDLE;
                    clr_addr <= clr_addr + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
